// File: rtl/ahb_spi_master_fifo_if.sv
// rtl/ahb_spi_master_fifo_if.sv - AHB-lite bus bundle for ahb_spi_master_fifo
interface ahb_spi_master_fifo_if;
  logic        HSEL;
  logic        HREADY;
  logic [31:0] HADDR;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA;
  logic        HREADYOUT;

  modport master (output HSEL, HREADY, HADDR, HWRITE, HSIZE, HWDATA,
                  input  HRDATA, HREADYOUT);
  modport slave  (input  HSEL, HREADY, HADDR, HWRITE, HSIZE, HWDATA,
                  output HRDATA, HREADYOUT);
endinterface

// File: rtl/ahb_spi_master_fifo.sv
// rtl/ahb_spi_master_fifo.sv - AHB-lite SPI master with TX/RX byte FIFOs, runtime CPOL/CPHA and divider.
// Defining AHB_SPI_IRQ_EN adds the SPI_IRQ_o output and the IRQEN register at 0x18.
module ahb_spi_master_fifo #(
  parameter int NUM_SS     = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int DIV_WIDTH  = 8
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  ahb_spi_master_fifo_if.slave  bus,
  input  logic                  SPI_MISO_i,
  output logic                  SPI_MOSI_o,
  output logic                  SPI_CLK_o,
  output logic [NUM_SS-1:0]     SPI_SS_o
`ifdef AHB_SPI_IRQ_EN
  , output logic                SPI_IRQ_o
`endif
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;
  localparam logic [2:0] A_CTRL = 3'd0, A_STAT = 3'd1, A_SS = 3'd2, A_DIV = 3'd3,
                         A_TX = 3'd4, A_RX = 3'd5, A_IRQ = 3'd6;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;
  state_e state_q, state_d;

  logic                 dp_valid_q, dp_write_q;
  logic [2:0]           dp_addr_q;
  logic                 en_q, cpha_q, cpol_q, tx_ovf_q, rx_ovf_q;
  logic [NUM_SS-1:0]    ss_q;
  logic [DIV_WIDTH-1:0] div_q, cnt_q, cnt_d;
  logic [3:0]           edge_q, edge_d;
  logic                 sck_q, sck_d, mosi_q, mosi_d;
  logic [7:0]           tx_sh_q, tx_sh_d, rx_sh_q, rx_sh_d;
  logic [7:0]           tx_mem [FIFO_DEPTH];
  logic [7:0]           rx_mem [FIFO_DEPTH];
  logic [AW:0]          tx_wp_q, tx_rp_q, rx_wp_q, rx_rp_q;
  logic                 tx_empty, tx_full, rx_empty, rx_full;
  logic                 tx_push, tx_pop, rx_push, rx_push_req, rx_pop, load;
  logic                 wr_en, rd_en, busy;
  logic [7:0]           tx_head, rx_head;
  logic [6:0]           status;
  logic [31:0]          rdata;
  logic                 unused_bus;

  assign unused_bus = ^{bus.HSIZE, bus.HADDR[31:5], bus.HADDR[1:0], bus.HWDATA};

  assign wr_en = dp_valid_q & dp_write_q;
  assign rd_en = dp_valid_q & ~dp_write_q;
  assign busy  = (state_q != IDLE);

  assign tx_empty = (tx_wp_q == tx_rp_q);
  assign tx_full  = (tx_wp_q[AW] != tx_rp_q[AW]) && (tx_wp_q[AW-1:0] == tx_rp_q[AW-1:0]);
  assign rx_empty = (rx_wp_q == rx_rp_q);
  assign rx_full  = (rx_wp_q[AW] != rx_rp_q[AW]) && (rx_wp_q[AW-1:0] == rx_rp_q[AW-1:0]);
  assign tx_head  = tx_mem[tx_rp_q[AW-1:0]];
  assign rx_head  = rx_mem[rx_rp_q[AW-1:0]];

  assign tx_push = wr_en && (dp_addr_q == A_TX) && !tx_full;
  assign rx_pop  = rd_en && (dp_addr_q == A_RX) && !rx_empty;
  assign rx_push = rx_push_req && !rx_full;

  assign status = {rx_ovf_q, tx_ovf_q, busy, rx_full, rx_empty, tx_full, tx_empty};

  assign SPI_SS_o      = ~ss_q;
  assign SPI_MOSI_o    = mosi_q;
  assign SPI_CLK_o     = (state_q == IDLE) ? cpol_q : sck_q;
  assign bus.HREADYOUT = 1'b1;
  assign bus.HRDATA    = rdata;

`ifdef AHB_SPI_IRQ_EN
  logic [6:0] irqen_q;
  logic       irq_q;
  assign SPI_IRQ_o = irq_q;
`endif

  always_comb begin
    rdata = '0;
    if (rd_en) begin
      case (dp_addr_q)
        A_CTRL: rdata[7:0] = {cpol_q, cpha_q, 5'b0, en_q};
        A_STAT: rdata[6:0] = status;
        A_SS:   rdata[NUM_SS-1:0] = ss_q;
        A_DIV:  rdata[DIV_WIDTH-1:0] = div_q;
        A_RX:   if (!rx_empty) rdata[7:0] = rx_head;
`ifdef AHB_SPI_IRQ_EN
        A_IRQ:  rdata[6:0] = irqen_q;
`endif
        default: rdata = '0;
      endcase
    end
  end

  // Edge index parity against CPHA picks sample vs shift; the final edge never shifts.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    edge_d      = edge_q;
    sck_d       = sck_q;
    mosi_d      = mosi_q;
    tx_sh_d     = tx_sh_q;
    rx_sh_d     = rx_sh_q;
    tx_pop      = 1'b0;
    rx_push_req = 1'b0;
    load        = 1'b0;
    case (state_q)
      IDLE: if (en_q && !tx_empty) load = 1'b1;
      SHIFT: begin
        if (cnt_q == div_q) begin
          cnt_d  = '0;
          sck_d  = ~sck_q;
          edge_d = edge_q + 4'd1;
          if (edge_q[0] == cpha_q) begin
            rx_sh_d = {rx_sh_q[6:0], SPI_MISO_i};
          end else if (edge_q != 4'd15) begin
            mosi_d  = tx_sh_q[7];
            tx_sh_d = {tx_sh_q[6:0], 1'b0};
          end
          if (edge_q == 4'd15) state_d = DONE;
        end else begin
          cnt_d = cnt_q + DIV_WIDTH'(1);
        end
      end
      DONE: begin
        rx_push_req = 1'b1;
        if (en_q && !tx_empty) load = 1'b1;
        else state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (load) begin
      tx_pop  = 1'b1;
      state_d = SHIFT;
      cnt_d   = '0;
      edge_d  = '0;
      sck_d   = cpol_q;
      if (cpha_q) begin
        tx_sh_d = tx_head;
      end else begin
        mosi_d  = tx_head[7];
        tx_sh_d = {tx_head[6:0], 1'b0};
      end
    end
  end

  always_ff @(posedge HCLK) begin
    if (tx_push) tx_mem[tx_wp_q[AW-1:0]] <= bus.HWDATA[7:0];
    if (rx_push) rx_mem[rx_wp_q[AW-1:0]] <= rx_sh_q;
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      edge_q     <= '0;
      sck_q      <= 1'b0;
      mosi_q     <= 1'b0;
      tx_sh_q    <= '0;
      rx_sh_q    <= '0;
      dp_valid_q <= 1'b0;
      dp_write_q <= 1'b0;
      dp_addr_q  <= '0;
      en_q       <= 1'b0;
      cpha_q     <= 1'b0;
      cpol_q     <= 1'b0;
      ss_q       <= '0;
      div_q      <= '0;
      tx_ovf_q   <= 1'b0;
      rx_ovf_q   <= 1'b0;
      tx_wp_q    <= '0;
      tx_rp_q    <= '0;
      rx_wp_q    <= '0;
      rx_rp_q    <= '0;
`ifdef AHB_SPI_IRQ_EN
      irqen_q    <= '0;
      irq_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      edge_q     <= edge_d;
      sck_q      <= sck_d;
      mosi_q     <= mosi_d;
      tx_sh_q    <= tx_sh_d;
      rx_sh_q    <= rx_sh_d;
      dp_valid_q <= bus.HSEL & bus.HREADY;
      dp_write_q <= bus.HWRITE;
      dp_addr_q  <= bus.HADDR[4:2];
      if (wr_en && dp_addr_q == A_CTRL) begin
        en_q <= bus.HWDATA[0];
        if (!busy) begin
          cpha_q <= bus.HWDATA[6];
          cpol_q <= bus.HWDATA[7];
        end
      end
      if (wr_en && dp_addr_q == A_SS) ss_q <= bus.HWDATA[NUM_SS-1:0];
      if (wr_en && dp_addr_q == A_DIV && !busy) div_q <= bus.HWDATA[DIV_WIDTH-1:0];
      if (wr_en && dp_addr_q == A_TX && tx_full) tx_ovf_q <= 1'b1;
      else if (wr_en && dp_addr_q == A_STAT && bus.HWDATA[5]) tx_ovf_q <= 1'b0;
      if (rx_push_req && rx_full) rx_ovf_q <= 1'b1;
      else if (wr_en && dp_addr_q == A_STAT && bus.HWDATA[6]) rx_ovf_q <= 1'b0;
      if (tx_push) tx_wp_q <= tx_wp_q + PTR_ONE;
      if (tx_pop)  tx_rp_q <= tx_rp_q + PTR_ONE;
      if (rx_push) rx_wp_q <= rx_wp_q + PTR_ONE;
      if (rx_pop)  rx_rp_q <= rx_rp_q + PTR_ONE;
`ifdef AHB_SPI_IRQ_EN
      if (wr_en && dp_addr_q == A_IRQ) irqen_q <= bus.HWDATA[6:0];
      irq_q <= |(status & irqen_q);
`endif
    end
  end
endmodule

// File: tb/tb_ahb_spi_master_fifo.sv
// tb/tb_ahb_spi_master_fifo.sv - directed and randomized loopback bench for ahb_spi_master_fifo
module tb_ahb_spi_master_fifo;
  localparam int NUM_SS = 4, DEPTH = 8, DW = 8;
  localparam logic [31:0] A_CTRL = 32'h00, A_STAT = 32'h04, A_SS = 32'h08, A_DIV = 32'h0C,
                          A_TX = 32'h10, A_RX = 32'h14, A_IRQ = 32'h18, A_UNM = 32'h1C;

  logic HCLK = 1'b0;
  logic HRESET = 1'b1;
  logic miso, mosi, sck;
  logic [NUM_SS-1:0] ss;
`ifdef AHB_SPI_IRQ_EN
  logic irq;
`endif

  int errors = 0;
  int checks = 0;

  ahb_spi_master_fifo_if bus();
  assign miso = mosi;

  ahb_spi_master_fifo #(.NUM_SS(NUM_SS), .FIFO_DEPTH(DEPTH), .DIV_WIDTH(DW)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .bus(bus),
    .SPI_MISO_i(miso), .SPI_MOSI_o(mosi), .SPI_CLK_o(sck), .SPI_SS_o(ss)
`ifdef AHB_SPI_IRQ_EN
    , .SPI_IRQ_o(irq)
`endif
  );

  always #5 HCLK = ~HCLK;

  // SPI slave model: captures MOSI on the mode's sampling edges while slave 0 is selected.
  logic [7:0] mon_q[$];
  int         mon_edges = 0;
  logic [7:0] mon_bits = 8'h00;
  logic       mon_prev = 1'b0;
  logic       cur_cpha = 1'b0;
  always @(negedge HCLK) begin
    if (HRESET) begin
      mon_edges = 0;
      mon_bits  = 8'h00;
    end else if (sck !== mon_prev && ss[0] == 1'b0) begin
      mon_edges++;
      if (((mon_edges % 2) == 1) != cur_cpha) mon_bits = {mon_bits[6:0], mosi};
      if (mon_edges == 16) begin
        mon_q.push_back(mon_bits);
        mon_edges = 0;
      end
    end
    mon_prev = sck;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    bus.HSEL = 1'b1; bus.HWRITE = 1'b1; bus.HADDR = a;
    @(posedge HCLK); #1;
    bus.HSEL = 1'b0; bus.HWRITE = 1'b0; bus.HWDATA = d;
    @(posedge HCLK); #1;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    bus.HSEL = 1'b1; bus.HWRITE = 1'b0; bus.HADDR = a;
    @(posedge HCLK); #1;
    bus.HSEL = 1'b0;
    d = bus.HRDATA;
    @(posedge HCLK); #1;
  endtask

  task automatic configure(input logic cpol, input logic cpha, input int div, input logic en);
    wr(A_SS, 32'h0);
    wr(A_DIV, div);
    wr(A_CTRL, {24'b0, cpol, cpha, 5'b0, en});
    wr(A_SS, 32'h1);
    cur_cpha = cpha;
  endtask

  task automatic watch(input int ncyc, output int edges, output int first_t, output int last_t);
    logic prev;
    prev = sck; edges = 0; first_t = -1; last_t = -1;
    for (int t = 0; t < ncyc; t++) begin
      if (sck !== prev) begin
        edges++;
        if (first_t < 0) first_t = t;
        last_t = t;
      end
      prev = sck;
      @(posedge HCLK); #1;
    end
  endtask

  task automatic wait_idle(input int bound);
    logic [31:0] s;
    int n;
    n = 0;
    do begin
      rd(A_STAT, s);
      n++;
    end while (!(s[0] && !s[4]) && n < bound);
    check("wait_idle", {31'b0, s[0] && !s[4]}, 32'h1);
  endtask

  initial begin
    logic [31:0] d;
    logic [7:0]  exp_q[$];
    logic [7:0]  b;
    logic        cpol, cpha;
    int          e, f, l, div, n, exp_last;

    bus.HSEL = 1'b0; bus.HREADY = 1'b1; bus.HWRITE = 1'b0;
    bus.HADDR = '0; bus.HWDATA = '0; bus.HSIZE = 3'b010;

    repeat (2) @(posedge HCLK);
    #1;
    check("rst_ss", {28'b0, ss}, 32'hF);
    check("rst_sck", {31'b0, sck}, 32'h0);
    check("rst_mosi", {31'b0, mosi}, 32'h0);
    check("rst_hrdata", bus.HRDATA, 32'h0);
    check("rst_hreadyout", {31'b0, bus.HREADYOUT}, 32'h1);
    HRESET = 1'b0;
    @(posedge HCLK); #1;
    rd(A_STAT, d); check("rst_status", d, 32'h05);
    rd(A_CTRL, d); check("rst_ctrl", d, 32'h0);
    rd(A_DIV, d);  check("rst_div", d, 32'h0);
    rd(A_UNM, d);  check("unmapped_rd", d, 32'h0);
    rd(A_TX, d);   check("txdata_rd", d, 32'h0);
`ifndef AHB_SPI_IRQ_EN
    wr(A_IRQ, 32'h7F);
    rd(A_IRQ, d);  check("irqen_absent", d, 32'h0);
`endif

    // Mode 0 single byte
    configure(1'b0, 1'b0, 1, 1'b1);
    check("mode0_ss", {28'b0, ss}, 32'hE);
    mon_q.delete();
    wr(A_TX, 32'hA5);
    watch(50, e, f, l);
    check("mode0_edges", e, 16);
    check("mode0_first", f, 3);
    check("mode0_last", l, 33);
    rd(A_RX, d); check("mode0_rx", d, 32'hA5);
    rd(A_STAT, d); check("mode0_status", d, 32'h05);
    check("mode0_mon_n", mon_q.size(), 1);
    if (mon_q.size() > 0) check("mode0_mon", {24'b0, mon_q[0]}, 32'hA5);

    // Modes 1..3
    for (int m = 1; m < 4; m++) begin
      cpol = m[1]; cpha = m[0];
      configure(cpol, cpha, 1, 1'b1);
      check("mode_idle_sck", {31'b0, sck}, {31'b0, cpol});
      mon_q.delete();
      wr(A_TX, 32'h3C);
      watch(50, e, f, l);
      check("mode_edges", e, 16);
      check("mode_first", f, 3);
      check("mode_last", l, 33);
      check("mode_end_sck", {31'b0, sck}, {31'b0, cpol});
      rd(A_RX, d); check("mode_rx", d, 32'h3C);
      check("mode_mon_n", mon_q.size(), 1);
      if (mon_q.size() > 0) check("mode_mon", {24'b0, mon_q[0]}, 32'h3C);
    end

    // Back-to-back, CLKDIV=0
    configure(1'b0, 1'b0, 0, 1'b0);
    mon_q.delete();
    for (int k = 1; k <= 4; k++) wr(A_TX, k);
    wr(A_CTRL, 32'h1);
    watch(90, e, f, l);
    check("b2b_edges", e, 64);
    check("b2b_first", f, 2);
    check("b2b_span", l - f, 4 * 17 - 2);
    for (int k = 1; k <= 4; k++) begin
      rd(A_RX, d); check("b2b_rx", d, k);
    end
    check("b2b_mon_n", mon_q.size(), 4);

    // Overflow handling
    configure(1'b0, 1'b0, 0, 1'b0);
    exp_q.delete();
    for (int k = 0; k <= DEPTH; k++) begin
      b = 8'($urandom_range(0, 255));
      exp_q.push_back(b);
      wr(A_TX, {24'b0, b});
    end
    rd(A_STAT, d); check("ovf_tx_status", d, 32'h26);
    wr(A_STAT, 32'h20);
    rd(A_STAT, d); check("ovf_tx_w1c", d, 32'h06);
    wr(A_CTRL, 32'h1);
    wait_idle(100);
    rd(A_STAT, d); check("ovf_rx_full", d, 32'h09);
    wr(A_TX, 32'hEE);
    wait_idle(20);
    rd(A_STAT, d); check("ovf_rx_status", d, 32'h49);
    for (int k = 0; k < DEPTH; k++) begin
      rd(A_RX, d); check("ovf_rx_data", d, {24'b0, exp_q[k]});
    end
    rd(A_STAT, d); check("ovf_drained", d, 32'h45);
    rd(A_RX, d);   check("rx_empty_pop", d, 32'h0);
    rd(A_STAT, d); check("rx_empty_noflag", d, 32'h45);
    wr(A_STAT, 32'h40);
    rd(A_STAT, d); check("ovf_rx_w1c", d, 32'h05);

    // Busy write lock on CLKDIV
    configure(1'b0, 1'b0, 1, 1'b1);
    wr(A_TX, 32'h5A);
    wr(A_DIV, 32'h7);
    watch(50, e, f, l);
    check("lock_edges", e, 16);
    check("lock_first", f, 1);
    check("lock_last", l, 31);
    rd(A_DIV, d); check("lock_div", d, 32'h1);
    rd(A_RX, d);  check("lock_rx", d, 32'h5A);

    // Reset during bit 3
    configure(1'b1, 1'b0, 1, 1'b1);
    wr(A_TX, 32'hFF);
    repeat (14) begin @(posedge HCLK); #1; end
    check("pre_rst_sck", {31'b0, sck}, 32'h1);
    check("pre_rst_mosi", {31'b0, mosi}, 32'h1);
    HRESET = 1'b1;
    #1;
    check("async_rst_ss", {28'b0, ss}, 32'hF);
    check("async_rst_sck", {31'b0, sck}, 32'h0);
    check("async_rst_mosi", {31'b0, mosi}, 32'h0);
    @(posedge HCLK); #1;
    HRESET = 1'b0;
    rd(A_STAT, d); check("post_rst_status", d, 32'h05);
    rd(A_CTRL, d); check("post_rst_ctrl", d, 32'h0);

    // Randomized modes, dividers and byte counts against the timing/loopback model
    for (int it = 0; it < 6; it++) begin
      cpol = 1'($urandom_range(0, 1));
      cpha = 1'($urandom_range(0, 1));
      div  = $urandom_range(0, 3);
      n    = $urandom_range(1, 4);
      configure(cpol, cpha, div, 1'b0);
      mon_q.delete();
      exp_q.delete();
      for (int k = 0; k < n; k++) begin
        b = 8'($urandom_range(0, 255));
        exp_q.push_back(b);
        wr(A_TX, {24'b0, b});
      end
      wr(A_CTRL, {24'b0, cpol, cpha, 6'b000001});
      exp_last = (div + 2) + (n - 1) * (16 * (div + 1) + 1) + 15 * (div + 1);
      watch(exp_last + 10, e, f, l);
      check("rnd_edges", e, 16 * n);
      check("rnd_first", f, div + 2);
      check("rnd_last", l, exp_last);
      check("rnd_mon_n", mon_q.size(), n);
      for (int k = 0; k < n; k++) begin
        rd(A_RX, d); check("rnd_rx", d, {24'b0, exp_q[k]});
        if (k < mon_q.size()) check("rnd_mon", {24'b0, mon_q[k]}, {24'b0, exp_q[k]});
      end
      rd(A_STAT, d); check("rnd_status", d, 32'h05);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ahb_spi_master_fifo.md
# ahb_spi_master_fifo

AHB-lite slave implementing a buffered, parametrised SPI master. It generalises the single-word SPI peripheral with:
- TX and RX byte FIFOs of configurable depth.
- Runtime CPOL/CPHA and SCK divider.
- A configurable number of active-low slave selects.

It sits on the AHB bus alongside the other memory-mapped peripherals and drives the board SPI pins directly.

## Interface
- `NUM_SS`, default 4: number of slave-select outputs (1–32).
- `FIFO_DEPTH`, default 8: entries per TX and RX FIFO; must be a power of 2, ≥2.
- `DIV_WIDTH`, default 8: width of the SCK divider register.
- `HCLK` in, 1: bus and core clock; all logic on its rising edge.
- `HRESET` in, 1: asynchronous, active-high reset.
- `HSEL` in, 1: AHB slave select.
- `HREADY` in, 1: previous transfer completing; address phase is sampled only when high.
- `HADDR` in, 32: address; `HADDR[4:2]` selects the register.
- `HWRITE` in, 1: write when high.
- `HSIZE` in, 3: ignored; all accesses are treated as word accesses, using the low bits.
- `HWDATA` in, 32: write data, valid in the data phase.
- `HRDATA` out, 32: read data, combinational from the registered address phase.
- `HREADYOUT` out, 1: tied to 1; the block never inserts wait states.
- `SPI_MISO_i` in, 1: serial data in.
- `SPI_MOSI_o` out, 1: serial data out.
- `SPI_CLK_o` out, 1: SCK.
- `SPI_SS_o` out, `NUM_SS`: active-low slave selects.

## Operation
Register map (word offsets):
- `0x00` CTRL (RW): bit0 `ENABLE`, bit6 `CPHA`, bit7 `CPOL`. Reset value 0.
- `0x04` STATUS:
  - Read-only bits: bit0 `TX_EMPTY`, bit1 `TX_FULL`, bit2 `RX_EMPTY`, bit3 `RX_FULL`, bit4 `BUSY`.
  - W1C sticky bits: bit5 `TX_OVF`, bit6 `RX_OVF`.
- `0x08` SS (RW): `SPI_SS_o` equals bitwise NOT of this register. Reset value 0, so all selects are high.
- `0x0C` CLKDIV (RW, `DIV_WIDTH` bits): SCK half-period is CLKDIV+1 `HCLK` cycles. Reset value 0.
- `0x10` TXDATA (WO): a write pushes `HWDATA[7:0]`. Reads return 0.
- `0x14` RXDATA (RO): a read returns `{24'b0, head}` and pops. Writes are ignored.
- Unmapped offsets: read 0, writes ignored.

Bus rules:
- An address phase is captured when `HREADY & HSEL`.
- Register writes take effect at the end of the data-phase cycle.

FIFO boundary conditions:
- Push to a full TX FIFO: the byte is dropped and `TX_OVF` is set.
- Pop from an empty RX FIFO: returns 0, the pointer is unchanged, no flag is set.
- Push and pop in the same cycle: both occur and the count is unchanged.
- Pointers have `$clog2(FIFO_DEPTH)+1` bits; full/empty is detected by comparing the MSB.
- A received byte arriving with the RX FIFO full is dropped and `RX_OVF` is set. TX continues regardless.

Engine FSM states are IDLE, SHIFT and DONE:
- **IDLE**:
  - `SPI_CLK_o` = `CPOL`.
  - If `ENABLE` and the TX FIFO is not empty: pop the byte into the shift register, then go to SHIFT.
- **SHIFT**:
  - The half-period counter counts CLKDIV+1 cycles, then SCK toggles. There are 16 edges per byte, and data is MSB first.
  - `CPHA`=0: MOSI is valid on entry; sample on odd edges, shift on even edges (the 16th edge is not shifted).
  - `CPHA`=1: shift on odd edges, sample on even edges.
  - After the 16th edge, go to DONE.
- **DONE** (one cycle):
  - Push the RX byte.
  - If `ENABLE` and the TX FIFO is not empty: pop the next byte and go to SHIFT (back-to-back transfer). Otherwise go to IDLE.

Other engine rules:
- `BUSY` = state ≠ IDLE.
- Writes to CPOL, CPHA or CLKDIV while `BUSY` are ignored. `ENABLE` and SS are always writable.
- Clearing `ENABLE` mid-byte finishes the current byte; the FIFOs are untouched.
- The SS register is fully software-controlled and is never altered by the engine.

## Timing
- Reset values:
  - `SPI_SS_o` is all ones.
  - `SPI_CLK_o`=0, `SPI_MOSI_o`=0, `HRDATA`=0, `HREADYOUT`=1.
  - Both FIFOs are empty, all flags are clear, and the FSM is in IDLE.
- Asserting `HRESET` mid-transfer returns all outputs to these values immediately, without waiting for a clock.
- TXDATA write data phase in cycle N: the FIFO is non-empty in N+1, and the FSM is in SHIFT in N+2.
- First SCK edge: CLKDIV+1 cycles after SHIFT is entered.
- Byte period: 16·(CLKDIV+1) cycles in SHIFT, plus 1 cycle in DONE.
- The RX byte is visible in RXDATA the cycle after DONE.

## Configuration
- `AHB_SPI_IRQ_EN` defined:
  - Adds output `SPI_IRQ_o` (1 bit) and register `0x18` IRQEN, whose bits mirror STATUS bits 0–6.
  - `SPI_IRQ_o` = |(STATUS & IRQEN), registered; it asserts one cycle after the condition arises.
- `AHB_SPI_IRQ_EN` undefined:
  - There is no `SPI_IRQ_o` port.
  - Offset `0x18` reads 0 and ignores writes.

## Test plan
- Mode 0 single byte: CLKDIV=1, CTRL=0x01, SS=0x1, write TXDATA=0xA5 with MISO looped to MOSI → `SPI_SS_o`=4'b1110, 8 SCK pulses of 2-cycle half-period, RXDATA reads 0xA5, then `RX_EMPTY`=1.
- Modes 1/2/3: byte 0x3C in each of CPOL/CPHA = 01, 10, 11 → the idle SCK level equals CPOL, the edge alignment matches the rules above, and loopback returns 0x3C.
- Back-to-back: CLKDIV=0, push 4 bytes 0x01–0x04 → 4 bytes in 4·17 = 68 cycles with no extra idle SCK gap, RX FIFO holds 0x01–0x04 in order.
- Overflow: with `ENABLE`=0, push FIFO_DEPTH+1 bytes → `TX_FULL`=1 and `TX_OVF`=1; W1C 0x20 clears `TX_OVF`. Then fill RX without reading → `RX_OVF`=1 and the extra byte is lost.
- Reset mid-transfer: assert `HRESET` during bit 3 of a transfer → SS all ones, SCK=0, MOSI=0 immediately, and STATUS reads 0x05 after release.
- Busy write lock: write CLKDIV=7 while `BUSY` → the value reads back unchanged and the current byte timing is unaffected.
